// File: rtl/usb_rx_line_decoder.sv
// Full-speed USB host-port receive front end: clock recovery, NRZI decode,
// SYNC detect, bit unstuffing, EOP detect and byte assembly.
// Optional build macro: USB_RX_STUFF_ERR_EN (flag a 1 in the stuff-bit slot).
module usb_rx_line_decoder #(
    parameter int OVERSAMPLE = 4,
    parameter int SYNC_MIN_Z = 5
) (
    input  logic       hi_clock,
    input  logic       reset,
    input  logic       rx_plus,
    input  logic       rx_minus,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_error,
    output logic [1:0] line_state
);

    localparam int PW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [PW-1:0] TICK = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] LAST = PW'(OVERSAMPLE - 1);
    localparam logic [3:0] MINZ = 4'(SYNC_MIN_Z);

    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_SE1 = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_EOP,
        S_ERR
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_phase;
    logic [1:0]    r_line;
    logic          r_prev;
    logic [2:0]    r_ones;
    logic [3:0]    r_cnt;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_flag;
    logic          r_partial;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_active;
    logic          r_error;

    logic w_edge;
    logic w_tick;
    logic w_jk;
    logic w_bit;

    // D+ change realigns the bit clock; decode is done on the registered line.
    assign w_edge = rx_plus ^ r_line[1];
    assign w_tick = (r_phase == TICK);
    assign w_jk   = r_line[1] ^ r_line[0];
    assign w_bit  = (r_line[1] == r_prev);

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign rx_active  = r_active;
    assign rx_error   = r_error;
    assign line_state = r_line;

    // Register the line and run the phase counter that defines the sample tick.
    always_ff @(posedge hi_clock) begin
        if (reset) begin
            r_line  <= 2'b00;
            r_phase <= '0;
        end else begin
            r_line <= {rx_plus, rx_minus};
            if (w_edge || r_phase == LAST) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + 1'b1;
            end
        end
    end

    // NRZI reference level (1 = J), updated on every J/K sample.
    always_ff @(posedge hi_clock) begin
        if (reset) begin
            r_prev <= 1'b1;
        end else if (w_tick && w_jk) begin
            r_prev <= r_line[1];
        end
    end

    // Packet FSM with registered strobes; advances only on sample ticks.
    always_ff @(posedge hi_clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ones    <= 3'd0;
            r_cnt     <= 4'd0;
            r_bitcnt  <= 3'd0;
            r_shift   <= 8'd0;
            r_flag    <= 1'b0;
            r_partial <= 1'b0;
            r_data    <= 8'd0;
            r_valid   <= 1'b0;
            r_active  <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
            if (w_tick) begin
                unique case (r_state)
                    S_IDLE: begin
                        if (r_line == LS_K) begin
                            r_state <= S_SYNC;
                            r_cnt   <= 4'd1;
                        end
                    end
                    S_SYNC: begin
                        if (r_line == LS_SE1) begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                            r_cnt   <= 4'd0;
                            r_flag  <= 1'b0;
                        end else if (r_line == LS_SE0) begin
                            r_state <= S_IDLE;
                        end else if (!w_bit) begin
                            if (r_cnt != 4'hF) begin
                                r_cnt <= r_cnt + 4'd1;
                            end
                        end else if (r_cnt >= MINZ) begin
                            r_state  <= S_DATA;
                            r_active <= 1'b1;
                            r_ones   <= 3'd0;
                            r_bitcnt <= 3'd0;
                            r_shift  <= 8'd0;
                        end else begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                            r_cnt   <= 4'd0;
                            r_flag  <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        if (r_line == LS_SE1) begin
                            r_state  <= S_ERR;
                            r_error  <= 1'b1;
                            r_active <= 1'b0;
                            r_cnt    <= 4'd0;
                            r_flag   <= 1'b0;
                        end else if (r_line == LS_SE0) begin
                            r_state   <= S_EOP;
                            r_flag    <= 1'b0;
                            r_partial <= (r_bitcnt != 3'd0);
                        end else if (r_ones == 3'd6) begin
`ifdef USB_RX_STUFF_ERR_EN
                            if (w_bit) begin
                                r_state  <= S_ERR;
                                r_error  <= 1'b1;
                                r_active <= 1'b0;
                                r_cnt    <= 4'd0;
                                r_flag   <= 1'b0;
                            end else begin
                                r_ones <= 3'd0;
                            end
`else
                            r_ones <= 3'd0;
`endif
                        end else begin
                            r_ones   <= w_bit ? r_ones + 3'd1 : 3'd0;
                            r_shift  <= {w_bit, r_shift[7:1]};
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                r_data  <= {w_bit, r_shift[7:1]};
                                r_valid <= 1'b1;
                            end
                        end
                    end
                    S_EOP: begin
                        if (r_line == LS_SE0) begin
                            r_flag <= 1'b1;
                        end else if (r_line == LS_J && r_flag) begin
                            r_state  <= S_IDLE;
                            r_active <= 1'b0;
                            r_error  <= r_partial;
                        end else begin
                            r_state  <= S_ERR;
                            r_error  <= 1'b1;
                            r_active <= 1'b0;
                            r_cnt    <= 4'd0;
                            r_flag   <= 1'b0;
                        end
                    end
                    S_ERR: begin
                        r_active <= 1'b0;
                        if (r_line == LS_SE0) begin
                            r_flag <= 1'b1;
                            r_cnt  <= 4'd0;
                        end else if (r_line == LS_J) begin
                            if (r_flag || r_cnt == 4'd7) begin
                                r_state <= S_IDLE;
                                r_flag  <= 1'b0;
                                r_cnt   <= 4'd0;
                            end else begin
                                r_cnt <= r_cnt + 4'd1;
                            end
                        end else begin
                            r_flag <= 1'b0;
                            r_cnt  <= 4'd0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_line_decoder.sv
// Directed bench for usb_rx_line_decoder: NRZI/stuffing encoder on the
// stimulus side, byte queue and strobe counters on the observation side.
module tb_usb_rx_line_decoder;

    localparam int OS = 4;
    localparam logic [1:0] J   = 2'b10;
    localparam logic [1:0] K   = 2'b01;
    localparam logic [1:0] SE0 = 2'b00;
    localparam logic [1:0] SE1 = 2'b11;

    logic       hi_clock = 1'b0;
    logic       reset;
    logic       rx_plus;
    logic       rx_minus;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_error;
    logic [1:0] line_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] q_rx[$];
    int n_errs = 0;
    int n_both = 0;
    int n_act = 0;
    logic [1:0] cur = J;
    int ones = 0;
    bit jit = 1'b0;
    int jit_idx = 0;

    usb_rx_line_decoder #(.OVERSAMPLE(OS), .SYNC_MIN_Z(5)) dut (
        .hi_clock   (hi_clock),
        .reset      (reset),
        .rx_plus    (rx_plus),
        .rx_minus   (rx_minus),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_active  (rx_active),
        .rx_error   (rx_error),
        .line_state (line_state)
    );

    always #5 hi_clock = ~hi_clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge hi_clock);
        #1;
        if (rx_valid === 1'b1) q_rx.push_back(rx_data);
        if (rx_error === 1'b1) n_errs++;
        if (rx_valid === 1'b1 && rx_error === 1'b1) n_both++;
        if (rx_active === 1'b1) n_act++;
    endtask

    task automatic hold(input logic [1:0] lv, input int n);
        {rx_plus, rx_minus} = lv;
        repeat (n) cyc();
    endtask

    task automatic tx_bit(input logic b);
        int len;
        len = OS;
        if (jit) begin
            len = (jit_idx % 2 == 1) ? OS - 1 : OS + 1;
            jit_idx++;
        end
        if (!b) cur = (cur == J) ? K : J;
        hold(cur, len);
    endtask

    task automatic tx_sync();
        cur = J;
        repeat (7) tx_bit(1'b0);
        tx_bit(1'b1);
        ones = 0;
    endtask

    task automatic tx_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            tx_bit(b[i]);
            ones = b[i] ? ones + 1 : 0;
            if (ones == 6) begin
                tx_bit(1'b0);
                ones = 0;
            end
        end
    endtask

    task automatic tx_eop();
        hold(SE0, 2 * OS);
        cur = J;
        hold(J, 6 * OS);
    endtask

    task automatic clr();
        q_rx.delete();
        n_errs = 0;
        n_act = 0;
    endtask

    initial begin
        reset = 1'b1;
        {rx_plus, rx_minus} = J;
        repeat (3) cyc();
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_active", 32'(rx_active), 32'd0);
        check("rst_error", 32'(rx_error), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_line", 32'(line_state), 32'd0);
        reset = 1'b0;
        hold(J, 8 * OS);
        check("idle_line_j", 32'(line_state), 32'(J));
        check("idle_active", 32'(rx_active), 32'd0);

        // Basic packet 0xA5
        clr();
        tx_sync();
        check("a5_active_after_sync", 32'(rx_active), 32'd1);
        tx_byte(8'hA5);
        tx_eop();
        check("a5_count", 32'(q_rx.size()), 32'd1);
        if (q_rx.size() > 0) check("a5_data", 32'(q_rx[0]), 32'hA5);
        check("a5_errs", 32'(n_errs), 32'd0);
        check("a5_active_cycles", 32'(n_act), 32'd44);
        check("a5_active_end", 32'(rx_active), 32'd0);

        // 0xFF with an inserted stuff bit
        clr();
        tx_sync();
        tx_byte(8'hFF);
        tx_eop();
        check("ff_count", 32'(q_rx.size()), 32'd1);
        if (q_rx.size() > 0) check("ff_data", 32'(q_rx[0]), 32'hFF);
        check("ff_errs", 32'(n_errs), 32'd0);

        // Seven line-constant bits after SYNC
        clr();
        tx_sync();
        repeat (7) tx_bit(1'b1);
`ifdef USB_RX_STUFF_ERR_EN
        check("stuff7_active", 32'(rx_active), 32'd0);
        check("stuff7_errs", 32'(n_errs), 32'd1);
`else
        check("stuff7_active", 32'(rx_active), 32'd1);
        check("stuff7_errs", 32'(n_errs), 32'd0);
`endif
        repeat (2) tx_bit(1'b1);
        tx_eop();
`ifdef USB_RX_STUFF_ERR_EN
        check("stuff7_count", 32'(q_rx.size()), 32'd0);
        check("stuff7_errs_total", 32'(n_errs), 32'd1);
`else
        check("stuff7_count", 32'(q_rx.size()), 32'd1);
        if (q_rx.size() > 0) check("stuff7_data", 32'(q_rx[0]), 32'hFF);
        check("stuff7_errs_total", 32'(n_errs), 32'd0);
`endif
        check("stuff7_active_end", 32'(rx_active), 32'd0);

        // Non-aligned EOP after 5 data bits, then a clean 0x3C
        clr();
        tx_sync();
        tx_bit(1'b1);
        tx_bit(1'b0);
        tx_bit(1'b1);
        tx_bit(1'b1);
        tx_bit(1'b0);
        check("short_errs_pre_eop", 32'(n_errs), 32'd0);
        tx_eop();
        check("short_errs", 32'(n_errs), 32'd1);
        check("short_count", 32'(q_rx.size()), 32'd0);
        check("short_active", 32'(rx_active), 32'd0);
        clr();
        tx_sync();
        tx_byte(8'h3C);
        tx_eop();
        check("3c_count", 32'(q_rx.size()), 32'd1);
        if (q_rx.size() > 0) check("3c_data", 32'(q_rx[0]), 32'h3C);
        check("3c_errs", 32'(n_errs), 32'd0);

        // Jittered 4-byte packet
        clr();
        jit = 1'b1;
        jit_idx = 0;
        tx_sync();
        tx_byte(8'h01);
        tx_byte(8'h80);
        tx_byte(8'h55);
        tx_byte(8'hC3);
        tx_eop();
        jit = 1'b0;
        check("jit_count", 32'(q_rx.size()), 32'd4);
        if (q_rx.size() == 4) begin
            check("jit_b0", 32'(q_rx[0]), 32'h01);
            check("jit_b1", 32'(q_rx[1]), 32'h80);
            check("jit_b2", 32'(q_rx[2]), 32'h55);
            check("jit_b3", 32'(q_rx[3]), 32'hC3);
        end
        check("jit_errs", 32'(n_errs), 32'd0);

        // SE1 mid-byte, recovery via SE0+J, then a clean 0x96
        clr();
        tx_sync();
        tx_bit(1'b1);
        tx_bit(1'b0);
        tx_bit(1'b0);
        tx_bit(1'b1);
        hold(SE1, OS);
        check("se1_active", 32'(rx_active), 32'd0);
        check("se1_errs", 32'(n_errs), 32'd1);
        hold(SE0, 2 * OS);
        cur = J;
        hold(J, 6 * OS);
        check("se1_errs_total", 32'(n_errs), 32'd1);
        check("se1_count", 32'(q_rx.size()), 32'd0);
        clr();
        tx_sync();
        tx_byte(8'h96);
        tx_eop();
        check("96_count", 32'(q_rx.size()), 32'd1);
        if (q_rx.size() > 0) check("96_data", 32'(q_rx[0]), 32'h96);
        check("96_errs", 32'(n_errs), 32'd0);

        // Reset held 3 cycles mid-byte, then a clean 0x5A
        tx_sync();
        tx_bit(1'b1);
        tx_bit(1'b0);
        tx_bit(1'b1);
        check("mid_active", 32'(rx_active), 32'd1);
        reset = 1'b1;
        cur = J;
        {rx_plus, rx_minus} = J;
        clr();
        repeat (3) cyc();
        check("mrst_valid", 32'(rx_valid), 32'd0);
        check("mrst_active", 32'(rx_active), 32'd0);
        check("mrst_error", 32'(rx_error), 32'd0);
        check("mrst_data", 32'(rx_data), 32'd0);
        reset = 1'b0;
        cyc();
        check("post_rst_active", 32'(rx_active), 32'd0);
        check("post_rst_valid", 32'(rx_valid), 32'd0);
        check("post_rst_error", 32'(rx_error), 32'd0);
        hold(J, 8 * OS);
        check("post_rst_strobes", 32'(n_errs + q_rx.size()), 32'd0);
        clr();
        tx_sync();
        tx_byte(8'h5A);
        tx_eop();
        check("5a_count", 32'(q_rx.size()), 32'd1);
        if (q_rx.size() > 0) check("5a_data", 32'(q_rx[0]), 32'h5A);
        check("5a_errs", 32'(n_errs), 32'd0);

        check("valid_error_overlap", 32'(n_both), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
